// File: rtl/tpu_job_scheduler.sv
// Job sequencer for the tpu core: queues matmul commands, launches them one at a time,
// supervises completion/timeout/abort and returns a tagged completion record.
module tpu_job_scheduler #(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]     cmd_m_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_k_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_n_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_base_a_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_base_b_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_base_p_i,
   input  logic [3:0]                cmd_tag_i,
   input  logic [CNT_W-1:0]          timeout_i,
   input  logic                      abort_i,
   output logic                      tpu_start_o,
   output logic [ADDR_WIDTH-1:0]     tpu_m_o,
   output logic [ADDR_WIDTH-1:0]     tpu_k_o,
   output logic [ADDR_WIDTH-1:0]     tpu_n_o,
   output logic [ADDR_WIDTH-1:0]     tpu_base_a_o,
   output logic [ADDR_WIDTH-1:0]     tpu_base_b_o,
   output logic [ADDR_WIDTH-1:0]     tpu_base_p_o,
   input  logic                      tpu_valid_i,
   output logic                      tpu_flush_o,
   output logic                      done_valid_o,
   input  logic                      done_ready_i,
   output logic [3:0]                done_tag_o,
   output logic [1:0]                done_err_o,
   output logic [CNT_W-1:0]          done_cycles_o,
   output logic                      busy_o,
   output logic [$clog2(DEPTH):0]    pending_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 6 * ADDR_WIDTH + 4;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_DIMS    = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_FLUSH,
      S_REPORT
   } state_t;

   state_t                  state_reg, state_next;
   logic [ENT_W-1:0]        mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]          count_reg;
   logic                    valid_q;
   logic [CNT_W-1:0]        cyc_reg, cyc_next, cyc_inc;
   logic                    flush_cnt_reg, flush_cnt_next;
   logic [3:0]              tag_reg;
   logic [1:0]              err_reg, err_next;
   logic [CNT_W-1:0]        cycles_reg, cycles_next;
   logic [ADDR_WIDTH-1:0]   m_reg, k_reg, n_reg, base_a_reg, base_b_reg, base_p_reg;

   logic                    full, empty, push, pop, valid_rise, head_bad;
   logic [ENT_W-1:0]        cmd_word, head_word;
   logic [ADDR_WIDTH-1:0]   head_m, head_k, head_n, head_a, head_b, head_p;
   logic [3:0]              head_tag;

   assign full  = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty = (count_reg == '0);
   // Abort wins over both FIFO ports so dropped jobs never reach the TPU.
   assign push  = cmd_valid_i & ~full & ~abort_i;
   assign pop   = (state_reg == S_IDLE) & ~empty & ~abort_i;

   assign cmd_word  = {cmd_tag_i, cmd_base_p_i, cmd_base_b_i, cmd_base_a_i,
                       cmd_n_i, cmd_k_i, cmd_m_i};
   assign head_word = mem[rd_ptr_reg];
   assign {head_tag, head_p, head_b, head_a, head_n, head_k, head_m} = head_word;
   assign head_bad  = (head_m == '0) | (head_k == '0) | (head_n == '0);

   assign valid_rise = tpu_valid_i & ~valid_q;
   assign cyc_inc    = (&cyc_reg) ? cyc_reg : cyc_reg + CNT_W'(1);

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_reg] <= cmd_word;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (abort_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_reg + PTR_W'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + (PTR_W+1)'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - (PTR_W+1)'(1);
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      cyc_next       = cyc_reg;
      flush_cnt_next = flush_cnt_reg;
      err_next       = err_reg;
      cycles_next    = cycles_reg;
      case (state_reg)
         S_IDLE: begin
            if (pop) begin
               if (head_bad) begin
                  state_next  = S_REPORT;
                  err_next    = ERR_DIMS;
                  cycles_next = '0;
               end else begin
                  state_next  = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            cyc_next   = '0;
            state_next = S_RUN;
         end
         S_RUN: begin
            // cyc_inc counts the current cycle, so the record includes the exit cycle.
            cyc_next = cyc_inc;
            if (valid_rise) begin
               state_next  = S_REPORT;
               err_next    = ERR_OK;
               cycles_next = cyc_inc;
            end else if (abort_i) begin
               state_next     = S_FLUSH;
               err_next       = ERR_ABORT;
               cycles_next    = cyc_inc;
               flush_cnt_next = 1'b0;
            end else if ((timeout_i != '0) && (cyc_inc == timeout_i)) begin
               state_next     = S_FLUSH;
               err_next       = ERR_TIMEOUT;
               cycles_next    = cyc_inc;
               flush_cnt_next = 1'b0;
            end
         end
         S_FLUSH: begin
            flush_cnt_next = 1'b1;
            if (flush_cnt_reg) begin
               state_next = S_REPORT;
            end
         end
         S_REPORT: begin
            if (done_ready_i) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= S_IDLE;
         valid_q       <= 1'b0;
         cyc_reg       <= '0;
         flush_cnt_reg <= 1'b0;
         err_reg       <= '0;
         cycles_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         valid_q       <= tpu_valid_i;
         cyc_reg       <= cyc_next;
         flush_cnt_reg <= flush_cnt_next;
         err_reg       <= err_next;
         cycles_reg    <= cycles_next;
      end
   end

   // Job configuration only moves on a pop, keeping the TPU inputs frozen for the whole job.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_reg      <= '0;
         k_reg      <= '0;
         n_reg      <= '0;
         base_a_reg <= '0;
         base_b_reg <= '0;
         base_p_reg <= '0;
         tag_reg    <= '0;
      end else if (pop) begin
         m_reg      <= head_m;
         k_reg      <= head_k;
         n_reg      <= head_n;
         base_a_reg <= head_a;
         base_b_reg <= head_b;
         base_p_reg <= head_p;
         tag_reg    <= head_tag;
      end
   end

   assign cmd_ready_o   = ~full;
   assign pending_o     = count_reg;
   assign tpu_start_o   = (state_reg == S_LAUNCH);
   assign tpu_flush_o   = (state_reg == S_FLUSH);
   assign done_valid_o  = (state_reg == S_REPORT);
   assign busy_o        = (state_reg != S_IDLE);
   assign done_tag_o    = tag_reg;
   assign done_err_o    = err_reg;
   assign done_cycles_o = cycles_reg;
   assign tpu_m_o       = m_reg;
   assign tpu_k_o       = k_reg;
   assign tpu_n_o       = n_reg;
   assign tpu_base_a_o  = base_a_reg;
   assign tpu_base_b_o  = base_b_reg;
   assign tpu_base_p_o  = base_p_reg;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Scoreboard bench for tpu_job_scheduler: a latency-scripted TPU model plus expected
// completion/config queues filled at push time and drained as the DUT responds.
module tb_tpu_job_scheduler;

   localparam int AW    = 12;
   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            cmd_valid_i, cmd_ready_o;
   logic [AW-1:0]   cmd_m_i, cmd_k_i, cmd_n_i, cmd_base_a_i, cmd_base_b_i, cmd_base_p_i;
   logic [3:0]      cmd_tag_i;
   logic [CW-1:0]   timeout_i;
   logic            abort_i;
   logic            tpu_start_o;
   logic [AW-1:0]   tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_a_o, tpu_base_b_o, tpu_base_p_o;
   logic            tpu_valid_i = 1'b0;
   logic            tpu_flush_o;
   logic            done_valid_o, done_ready_i;
   logic [3:0]      done_tag_o;
   logic [1:0]      done_err_o;
   logic [CW-1:0]   done_cycles_o;
   logic            busy_o;
   logic [$clog2(DEPTH):0] pending_o;

   tpu_job_scheduler #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_m_i(cmd_m_i), .cmd_k_i(cmd_k_i), .cmd_n_i(cmd_n_i),
      .cmd_base_a_i(cmd_base_a_i), .cmd_base_b_i(cmd_base_b_i), .cmd_base_p_i(cmd_base_p_i),
      .cmd_tag_i(cmd_tag_i), .timeout_i(timeout_i), .abort_i(abort_i),
      .tpu_start_o(tpu_start_o),
      .tpu_m_o(tpu_m_o), .tpu_k_o(tpu_k_o), .tpu_n_o(tpu_n_o),
      .tpu_base_a_o(tpu_base_a_o), .tpu_base_b_o(tpu_base_b_o), .tpu_base_p_o(tpu_base_p_o),
      .tpu_valid_i(tpu_valid_i), .tpu_flush_o(tpu_flush_o),
      .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
      .done_tag_o(done_tag_o), .done_err_o(done_err_o), .done_cycles_o(done_cycles_o),
      .busy_o(busy_o), .pending_o(pending_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  tag;
      logic [1:0]  err;
      logic [15:0] cyc;
      int          flushes;
   } exp_t;

   typedef struct {
      logic [AW-1:0] m, k, n, a, b, p;
   } cfg_t;

   exp_t exp_q[$];
   cfg_t cfg_q[$];
   int   lat_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int start_cnt   = 0;
   int exp_starts  = 0;
   int flush_cnt   = 0;
   int tpu_cnt     = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // TPU model and start/config monitor. Latency -1 leaves tpu_valid_i as it was and never
   // responds; 0 lowers it and never responds; N raises it in the Nth RUN cycle.
   always @(negedge clk_i) begin
      if (rst_i) begin
         tpu_valid_i = 1'b0;
         tpu_cnt     = 0;
         flush_cnt   = 0;
      end else begin
         if (tpu_flush_o) flush_cnt++;
         if (tpu_start_o) begin
            int   l;
            cfg_t c;
            start_cnt++;
            if (cfg_q.size() == 0) begin
               check("spurious_start", 32'(1), 32'(0));
            end else begin
               c = cfg_q.pop_front();
               check("cfg_m", 32'(tpu_m_o), 32'(c.m));
               check("cfg_k", 32'(tpu_k_o), 32'(c.k));
               check("cfg_n", 32'(tpu_n_o), 32'(c.n));
               check("cfg_a", 32'(tpu_base_a_o), 32'(c.a));
               check("cfg_b", 32'(tpu_base_b_o), 32'(c.b));
               check("cfg_p", 32'(tpu_base_p_o), 32'(c.p));
            end
            l = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            if (l >= 0) tpu_valid_i = 1'b0;
            tpu_cnt = (l > 0) ? l : 0;
            $display("start m=%0d k=%0d n=%0d lat=%0d", tpu_m_o, tpu_k_o, tpu_n_o, l);
         end else if (tpu_cnt > 0) begin
            tpu_cnt--;
            if (tpu_cnt == 0) tpu_valid_i = 1'b1;
         end
      end
   end

   // Completion consumer: compares each handshaken record with the scoreboard head.
   always @(negedge clk_i) begin
      if (!rst_i && done_valid_o && done_ready_i) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'(1), 32'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_tag", 32'(done_tag_o), 32'(e.tag));
            check("done_err", 32'(done_err_o), 32'(e.err));
            check("done_cycles", 32'(done_cycles_o), 32'(e.cyc));
            check("flush_len", 32'(flush_cnt), 32'(e.flushes));
         end
         $display("done tag=%0d err=%0d cycles=%0d", done_tag_o, done_err_o, done_cycles_o);
         flush_cnt = 0;
      end
   end

   task automatic push_job(input logic [AW-1:0] m, k, n, a, b, p, input logic [3:0] tag,
                           input int lat, input bit launches, input bit completes,
                           input logic [1:0] err, input logic [15:0] cyc, output bit acc);
      cfg_t c;
      exp_t e;
      cmd_m_i = m; cmd_k_i = k; cmd_n_i = n;
      cmd_base_a_i = a; cmd_base_b_i = b; cmd_base_p_i = p;
      cmd_tag_i = tag;
      cmd_valid_i = 1'b1;
      acc = cmd_ready_o;
      if (acc && launches) begin
         c.m = m; c.k = k; c.n = n; c.a = a; c.b = b; c.p = p;
         cfg_q.push_back(c);
         lat_q.push_back(lat);
         exp_starts++;
      end
      if (acc && completes) begin
         e.tag = tag; e.err = err; e.cyc = cyc;
         e.flushes = (err == 2'd1 || err == 2'd3) ? 2 : 0;
         exp_q.push_back(e);
      end
      @(posedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      $display("push tag=%0d accepted=%0d", tag, acc);
   endtask

   task automatic drain(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk_i);
      check("drain_left", 32'(exp_q.size()), 32'(0));
      @(negedge clk_i);
      check("idle_after_drain", 32'(busy_o), 32'(0));
   endtask

   task automatic wait_start(input int limit);
      for (int i = 0; i < limit && !tpu_start_o; i++) @(negedge clk_i);
      check("start_seen", 32'(tpu_start_o), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int s0;
      rst_i = 1'b1;
      cmd_valid_i = 1'b0; abort_i = 1'b0; timeout_i = '0; done_ready_i = 1'b1;
      cmd_m_i = '0; cmd_k_i = '0; cmd_n_i = '0; cmd_tag_i = '0;
      cmd_base_a_i = '0; cmd_base_b_i = '0; cmd_base_p_i = '0;
      repeat (3) @(negedge clk_i);
      check("rst_ready", 32'(cmd_ready_o), 32'(1));
      check("rst_pending", 32'(pending_o), 32'(0));
      check("rst_busy", 32'(busy_o), 32'(0));
      check("rst_start", 32'(tpu_start_o), 32'(0));
      check("rst_done_valid", 32'(done_valid_o), 32'(0));
      check("rst_cycles", 32'(done_cycles_o), 32'(0));
      rst_i = 1'b0;
      @(negedge clk_i);

      // Single job
      push_job(12'd10, 12'd10, 12'd10, 12'h000, 12'h100, 12'h200, 4'd5, 40, 1, 1, 2'd0, 16'd40, acc);
      check("single_acc", 32'(acc), 32'(1));
      drain(200);

      // FIFO full behind a long-running job
      push_job(12'd4, 12'd5, 12'd6, 12'h010, 12'h020, 12'h030, 4'd1, 60, 1, 1, 2'd0, 16'd60, acc);
      for (int i = 0; i < 4; i++) begin
         push_job(12'(i + 1), 12'(i + 2), 12'(i + 3), 12'(16 * i), 12'(16 * i + 1), 12'(16 * i + 2),
                  4'(i + 2), i + 5, 1, 1, 2'd0, 16'(i + 5), acc);
         check("fill_acc", 32'(acc), 32'(1));
      end
      check("full_pending", 32'(pending_o), 32'(4));
      check("full_ready", 32'(cmd_ready_o), 32'(0));
      push_job(12'd1, 12'd1, 12'd1, 12'h0, 12'h0, 12'h0, 4'd6, 3, 1, 1, 2'd0, 16'd3, acc);
      check("full_reject", 32'(acc), 32'(0));
      drain(600);

      // Timeout with an unresponsive TPU
      timeout_i = 16'd8;
      push_job(12'd2, 12'd2, 12'd2, 12'h040, 12'h050, 12'h060, 4'd3, 0, 1, 1, 2'd1, 16'd8, acc);
      drain(100);
      timeout_i = '0;

      // Zero dimension, followed by a good job
      push_job(12'd3, 12'd0, 12'd3, 12'h0, 12'h0, 12'h0, 4'd7, 0, 0, 1, 2'd2, 16'd0, acc);
      push_job(12'd7, 12'd8, 12'd9, 12'h111, 12'h222, 12'h333, 4'd8, 12, 1, 1, 2'd0, 16'd12, acc);
      drain(100);

      // tpu_valid_i left high must not complete the following job
      push_job(12'd1, 12'd2, 12'd3, 12'h001, 12'h002, 12'h003, 4'd9, 10, 1, 1, 2'd0, 16'd10, acc);
      drain(100);
      timeout_i = 16'd20;
      push_job(12'd5, 12'd5, 12'd5, 12'h005, 12'h006, 12'h007, 4'd10, -1, 1, 1, 2'd1, 16'd20, acc);
      drain(100);
      timeout_i = '0;

      // Abort during RUN with two jobs queued
      push_job(12'd6, 12'd6, 12'd6, 12'h300, 12'h310, 12'h320, 4'd11, 0, 1, 1, 2'd3, 16'd5, acc);
      wait_start(20);
      push_job(12'd1, 12'd1, 12'd1, 12'h0, 12'h0, 12'h0, 4'd12, 5, 0, 0, 2'd0, 16'd0, acc);
      check("abort_q1_acc", 32'(acc), 32'(1));
      push_job(12'd1, 12'd1, 12'd1, 12'h0, 12'h0, 12'h0, 4'd13, 5, 0, 0, 2'd0, 16'd0, acc);
      check("abort_q2_acc", 32'(acc), 32'(1));
      repeat (3) @(negedge clk_i);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      check("abort_pending", 32'(pending_o), 32'(0));
      drain(50);
      repeat (10) @(negedge clk_i);
      check("abort_no_start", 32'(start_cnt), 32'(exp_starts));

      // Back-pressure on the completion record
      done_ready_i = 1'b0;
      push_job(12'd9, 12'd9, 12'd9, 12'h0a0, 12'h0b0, 12'h0c0, 4'd14, 10, 1, 1, 2'd0, 16'd10, acc);
      push_job(12'd3, 12'd4, 12'd5, 12'h0d0, 12'h0e0, 12'h0f0, 4'd15, 4, 1, 1, 2'd0, 16'd4, acc);
      for (int i = 0; i < 100 && !done_valid_o; i++) @(negedge clk_i);
      s0 = start_cnt;
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 32'(done_valid_o), 32'(1));
         check("bp_tag", 32'(done_tag_o), 32'(14));
         check("bp_err", 32'(done_err_o), 32'(0));
         check("bp_cycles", 32'(done_cycles_o), 32'(10));
         @(negedge clk_i);
      end
      check("bp_no_start", 32'(start_cnt), 32'(s0));
      done_ready_i = 1'b1;
      drain(100);

      // Asynchronous reset in the middle of RUN
      push_job(12'd4, 12'd4, 12'd4, 12'h123, 12'h234, 12'h345, 4'd6, 0, 1, 0, 2'd0, 16'd0, acc);
      push_job(12'd4, 12'd4, 12'd4, 12'h1, 12'h2, 12'h3, 4'd2, 0, 0, 0, 2'd0, 16'd0, acc);
      wait_start(20);
      repeat (3) @(negedge clk_i);
      check("start_total", 32'(start_cnt), 32'(exp_starts));
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy", 32'(busy_o), 32'(0));
      check("arst_ready", 32'(cmd_ready_o), 32'(1));
      check("arst_pending", 32'(pending_o), 32'(0));
      check("arst_start", 32'(tpu_start_o), 32'(0));
      check("arst_flush", 32'(tpu_flush_o), 32'(0));
      check("arst_done_valid", 32'(done_valid_o), 32'(0));
      check("arst_tag", 32'(done_tag_o), 32'(0));
      check("arst_m", 32'(tpu_m_o), 32'(0));
      check("arst_base_p", 32'(tpu_base_p_o), 32'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("post_rst_busy", 32'(busy_o), 32'(0));
      check("post_rst_start", 32'(start_cnt), 32'(exp_starts));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tpu_job_scheduler.md
# tpu_job_scheduler

Command-queue sequencer in front of the `tpu` core. It buffers matrix-multiply jobs (m, k, n, three base addresses, tag) in a small FIFO and launches them one at a time. It holds the TPU configuration stable while a job runs, then waits for completion or a timeout/abort and returns a tagged completion record with a cycle count. It sits between the host/AXI-lite control logic and the `tpu` start/valid interface.

## Interface
- `ADDR_WIDTH`, 12: width of m/k/n and base-address fields; matches the TPU address width.
- `DEPTH`, 4: command FIFO entries; must be a power of 2, ≥2.
- `CNT_W`, 16: width of the cycle counter and the timeout field.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `cmd_valid_i`  in  1  command offered.
- `cmd_ready_o`  out  1  FIFO not full.
- `cmd_m_i`, `cmd_k_i`, `cmd_n_i`  in  ADDR_WIDTH each  matrix dimensions.
- `cmd_base_a_i`, `cmd_base_b_i`, `cmd_base_p_i`  in  ADDR_WIDTH each  BRAM base addresses.
- `cmd_tag_i`  in  4  job identifier, echoed on completion.
- `timeout_i`  in  CNT_W  RUN-cycle limit; 0 disables the timeout.
- `abort_i`  in  1  level; kills the active job and drops queued jobs.
- `tpu_start_o`  out  1  one-cycle launch pulse to the TPU.
- `tpu_m_o`, `tpu_k_o`, `tpu_n_o`, `tpu_base_a_o`, `tpu_base_b_o`, `tpu_base_p_o`  out  ADDR_WIDTH each  registered job configuration.
- `tpu_valid_i`  in  1  TPU done; only its rising edge is used.
- `tpu_flush_o`  out  1  active-high TPU reset request; the top level inverts it into the TPU `rst_ni`.
- `done_valid_o`  out  1  completion record valid.
- `done_ready_i`  in  1  completion consumed.
- `done_tag_o`  out  4  tag of the completed job.
- `done_err_o`  out  2  completion code: 0 ok, 1 timeout, 2 bad dimensions, 3 abort.
- `done_cycles_o`  out  CNT_W  RUN cycles for the job; saturates.
- `busy_o`  out  1  state ≠ IDLE.
- `pending_o`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO behaviour:
  - Push when `cmd_valid_i & cmd_ready_o`. `cmd_ready_o = !full`; there is no same-cycle bypass when the FIFO is full.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states and transitions:
  - IDLE: if the FIFO is not empty, pop the head and latch its fields into the `tpu_*` config registers and the tag register.
    - Any of m, k, n equal to 0 → REPORT with err=2, cycles=0; no TPU launch.
    - Otherwise → LAUNCH.
  - LAUNCH (1 cycle): `tpu_start_o`=1, cycle counter cleared → RUN.
  - RUN: the counter increments every cycle and saturates at all-ones. Conditions, in priority order:
    - Rising edge of `tpu_valid_i` (`tpu_valid_i & ~valid_q`, with `valid_q` registered every cycle) → REPORT, err=0.
    - Else `abort_i` → FLUSH, err=3.
    - Else `timeout_i`≠0 and counter==`timeout_i` → FLUSH, err=1.
  - FLUSH: `tpu_flush_o`=1 for exactly 2 cycles → REPORT.
  - REPORT: `done_valid_o`=1. Tag, err and cycles are held stable until `done_ready_i`; on the handshake → IDLE.
- Abort behaviour:
  - `abort_i` in any state clears the FIFO; dropped jobs produce no completion record.
  - In IDLE, LAUNCH or REPORT, abort does not affect the current state or record.
  - LAUNCH always proceeds to RUN; abort there is handled in RUN on the next cycle.
  - Pushes are ignored in any cycle where `abort_i`=1.
- Config stability: the `tpu_*` config registers change only at a pop; they stay constant from LAUNCH through REPORT.

## Timing
- Reset values: all outputs 0, except `cmd_ready_o`=1. State=IDLE, FIFO empty, `valid_q`=0.
- Reset asserted mid-job returns to IDLE immediately, empties the FIFO and deasserts `done_valid_o`. No flush pulse is generated; the TPU shares the system reset.
- Launch latency, for a push at edge E0 into an empty FIFO while IDLE:
  - Pop and config valid after edge E1.
  - `tpu_start_o` high between E1 and E2.
  - RUN from E2.
- Completion latency: a `tpu_valid_i` rise sampled at edge R gives `done_valid_o`=1 after R. `done_cycles_o` = number of RUN cycles, including the edge-R cycle.
- Back-to-back jobs: after the REPORT handshake at edge H, a queued job pops at H+1, so `tpu_start_o` is high in the cycle after H+1. Minimum start-to-start spacing is RUN length + 3 cycles.
- `tpu_valid_i` stuck high from a previous job creates no new rising edge, so it cannot complete the next job early.

## Test plan
- Single job: push m=k=n=10, bases 0x000/0x100/0x200, tag 5; TPU model raises valid 40 cycles after start → one start pulse, config = pushed values, done tag=5, err=0, cycles=40.
- FIFO full: push 5 jobs back-to-back while RUN is blocked → 4 accepted, `cmd_ready_o`=0 on the 5th, `pending_o`=4; tags complete in push order.
- Timeout: `timeout_i`=8, TPU never responds → `tpu_flush_o` high exactly 2 cycles, then done err=1, cycles=8.
- Bad dims: push k=0 → no `tpu_start_o`, done err=2, cycles=0; the next valid job still launches.
- Abort: abort during RUN with 2 jobs queued → flush 2 cycles, done err=3, `pending_o`=0, no further starts.
- Back-pressure and reset: hold `done_ready_i`=0 for 10 cycles → record stable, no new start. Then assert `rst_i` mid-RUN → all outputs return to reset values asynchronously.
